data_memory: RTL and testbench



---
 rtl/data_memory.sv | 116 +++++++++++
 tb/tb_data_memory.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: line-wide backing store behind the data cache.
// Accepts one line read or write at a time, completes it a fixed number of
// cycles after accept and signals completion with a one-cycle ack pulse.
// Request inputs are captured at accept, so the requester may change them
// freely while a transaction is in flight.
module data_memory #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                wr_q, wr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, ack_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic                mem_we;
    logic [LINE_W-1:0]   mem_q [DEPTH];

    // Byte offset and aliasing high address bits carry no meaning here
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    // Next-state logic: accept in IDLE, count down in BUSY, pulse ack once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[5 +: IDX_W];
                    wr_d    = write_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    mem_we  = wr_q;
                    if (!wr_q) begin
                        rdata_d = mem_q[idx_q];
                    end
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and request latches; reset abandons any transaction in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Line array, written only at the completion edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed checks of data_memory latency, read/write paths,
// input isolation while busy, mid-transaction reset and address aliasing.
// A second instance built with LATENCY=1 shares the stimulus.
module tb_data_memory;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         enable_i;
    logic         write_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         ack1_o;
    logic [255:0] data1_o;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] LINE_A = {8{32'hAAAA_AAAA}};
    localparam logic [255:0] LINE_W = {8{32'h1234_5678}};
    localparam logic [255:0] LINE_B = {8{32'hB0B0_0001}};
    localparam logic [255:0] LINE_F = {8{32'hF00D_F00D}};
    localparam logic [255:0] LINE_C = {8{32'hC0DE_C0DE}};
    localparam logic [255:0] LINE_D = {8{32'hD1D2_D3D4}};
    localparam logic [255:0] LINE_E = {8{32'hEEEE_0707}};
    localparam logic [255:0] LINE_X = {8{32'h5555_5555}};
    localparam logic [255:0] LINE_G = {8{32'h6060_6060}};

    data_memory dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    data_memory #(.LATENCY(1)) dut1 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack1_o),
        .data_o   (data1_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Compare one observed value against the bench's expectation
    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request and let the accept edge happen
    task automatic apply_stimulus(input logic [31:0] addr, input logic wr, input logic [255:0] data);
        addr_i   = addr;
        write_i  = wr;
        data_i   = data;
        enable_i = 1'b1;
        tick();
    endtask

    // Count edges until ack is seen; a missing ack is a failed check
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack_o !== 1'b1 && n < 50);
        if (ack_o !== 1'b1) begin
            check_output("ack_timeout", 256'(ack_o), 256'd1);
        end
    endtask

    // Complete a full write transaction through the ports and return to IDLE
    task automatic write_line(input logic [31:0] addr, input logic [255:0] data);
        int n;
        apply_stimulus(addr, 1'b1, data);
        enable_i = 1'b0;
        wait_ack(n);
        tick();
    endtask

    // Count acks seen over a number of edges
    task automatic count_acks(input int cycles, output int acks);
        acks = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ack_o === 1'b1) acks++;
        end
    endtask

    initial begin
        int n;
        int n2;
        int acks;

        rst_i    = 1'b0;
        enable_i = 1'b0;
        write_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        tick();
        tick();
        check_output("reset_ack", 256'(ack_o), 256'd0);
        check_output("reset_data", data_o, 256'd0);
        check_output("reset_ack_lat1", 256'(ack1_o), 256'd0);
        rst_i = 1'b1;
        tick();

        // Line read with the full latency
        write_line(32'h0000_0060, LINE_A);
        apply_stimulus(32'h0000_0060, 1'b0, '0);
        enable_i = 1'b0;
        wait_ack(n);
        check_output("t1_latency", 256'(n), 256'd10);
        check_output("t1_data", data_o, LINE_A);
        tick();
        check_output("t1_ack_one_cycle", 256'(ack_o), 256'd0);
        tick();

        // Write then read back; a write ack leaves data_o alone
        apply_stimulus(32'h0000_0400, 1'b1, LINE_W);
        enable_i = 1'b0;
        wait_ack(n);
        check_output("t2_write_latency", 256'(n), 256'd10);
        check_output("t2_data_held", data_o, LINE_A);
        tick();
        apply_stimulus(32'h0000_0400, 1'b0, '0);
        enable_i = 1'b0;
        wait_ack(n);
        check_output("t2_readback", data_o, LINE_W);
        tick();

        // Write-back followed by fill with enable held high throughout
        write_line(32'h0000_04C0, LINE_F);
        apply_stimulus(32'h0000_00C0, 1'b1, LINE_B);
        wait_ack(n);
        check_output("t3_wb_latency", 256'(n), 256'd10);
        write_i = 1'b0;
        addr_i  = 32'h0000_04C0;
        data_i  = '0;
        wait_ack(n2);
        check_output("t3_ack_gap", 256'(n2), 256'd12);
        check_output("t3_fill_data", data_o, LINE_F);
        enable_i = 1'b0;
        count_acks(20, acks);
        check_output("t3_no_third_ack", 256'(acks), 256'd0);
        apply_stimulus(32'h0000_00C0, 1'b0, '0);
        enable_i = 1'b0;
        wait_ack(n);
        check_output("t3_wb_stored", data_o, LINE_B);
        tick();

        // Input churn while busy must not disturb the accepted request
        write_line(32'h0000_0000, LINE_D);
        write_line(32'h0000_0120, LINE_C);
        apply_stimulus(32'h0000_0120, 1'b0, '0);
        n = 0;
        do begin
            tick();
            n++;
            if (ack_o !== 1'b1) begin
                addr_i   = 32'h0000_0000;
                write_i  = (n % 2 == 0);
                data_i   = {8{32'hDEAD_0000 | 32'(n)}};
                enable_i = (n % 2 == 1);
            end
        end while (ack_o !== 1'b1 && n < 50);
        enable_i = 1'b0;
        write_i  = 1'b0;
        check_output("t4_latency", 256'(n), 256'd10);
        check_output("t4_data", data_o, LINE_C);
        tick();
        apply_stimulus(32'h0000_0000, 1'b0, '0);
        enable_i = 1'b0;
        wait_ack(n);
        check_output("t4_line0_untouched", data_o, LINE_D);
        tick();

        // Reset in the middle of a write discards it
        write_line(32'h0000_00E0, LINE_E);
        apply_stimulus(32'h0000_00E0, 1'b1, LINE_X);
        enable_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_i = 1'b0;
        #1;
        check_output("t5_reset_ack", 256'(ack_o), 256'd0);
        check_output("t5_reset_data", data_o, 256'd0);
        tick();
        tick();
        rst_i = 1'b1;
        count_acks(15, acks);
        check_output("t5_no_ack", 256'(acks), 256'd0);
        apply_stimulus(32'h0000_00E0, 1'b0, '0);
        enable_i = 1'b0;
        wait_ack(n);
        check_output("t5_next_latency", 256'(n), 256'd10);
        check_output("t5_line7_kept", data_o, LINE_E);
        tick();

        // Address aliasing and the single-cycle latency build
        write_line(32'h0000_4020, LINE_G);
        tick();
        apply_stimulus(32'h0000_0020, 1'b0, '0);
        enable_i = 1'b0;
        check_output("t6_lat1_not_yet", 256'(ack1_o), 256'd0);
        tick();
        check_output("t6_lat1_ack", 256'(ack1_o), 256'd1);
        check_output("t6_lat1_data", data1_o, LINE_G);
        check_output("t6_lat10_quiet", 256'(ack_o), 256'd0);
        tick();
        check_output("t6_lat1_pulse", 256'(ack1_o), 256'd0);
        wait_ack(n);
        check_output("t6_latency", 256'(n), 256'd8);
        check_output("t6_alias_data", data_o, LINE_G);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
